// File: rtl/regfile_read_port_if.sv
// Operand read channel between the register-file read port and the execute stage.
// The requester (execute side) drives the request and output-ready; the read port answers.
interface regfile_read_port_if #(
  parameter int DW = 32,
  parameter int IW = 5
);
  logic          Req_valid;
  logic          Req_ready;
  logic [IW-1:0] Ra;
  logic [IW-1:0] Rb;
  logic          Out_valid;
  logic          Out_ready;
  logic [DW-1:0] Qa;
  logic [DW-1:0] Qb;

  modport master (
    output Req_valid, Ra, Rb, Out_ready,
    input  Req_ready, Out_valid, Qa, Qb
  );

  modport slave (
    input  Req_valid, Ra, Rb, Out_ready,
    output Req_ready, Out_valid, Qa, Qb
  );
endinterface

// File: rtl/regfile_read_port.sv
// Dual-operand read port of the 32x32 register bank with an in-flight-write scoreboard.
// Define RF_BYPASS_EN to forward a source that is being written this cycle from Wr_D.
module regfile_read_port #(
  parameter  int NREG = 32,
  parameter  int DW   = 32,
  localparam int IW   = $clog2(NREG)
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [NREG*DW-1:0] Q_flat,
  input  logic [DW-1:0]      Wr_D,
  input  logic [NREG-1:0]    Wr_En,
  input  logic               Iss_valid,
  input  logic [IW-1:0]      Iss_dest,
  regfile_read_port_if.slave rd
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   qa_q, qa_d;
  logic [DW-1:0]   qb_q, qb_d;

  logic [DW-1:0]   q_bank [NREG];
  logic            fwd_a, fwd_b;
  logic            hz;
  logic            req_ready;
  logic            accept;

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      q_bank[i] = Q_flat[i*DW +: DW];
    end
  end

`ifdef RF_BYPASS_EN
  assign fwd_a = Wr_En[rd.Ra] & (rd.Ra != '0);
  assign fwd_b = Wr_En[rd.Rb] & (rd.Rb != '0);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  // busy_q[0] is held at zero, so r0 can never raise a hazard.
  assign hz        = (busy_q[rd.Ra] & ~fwd_a) | (busy_q[rd.Rb] & ~fwd_b);
  assign req_ready = ~hz & (~out_valid_q | rd.Out_ready);
  assign accept    = rd.Req_valid & req_ready;

  // Issue sets, a completing write clears; issue wins when both hit the same entry.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    busy_d = busy_q;
    for (int i = 0; i < NREG; i++) begin
      if (i == 0) begin
        busy_d[i] = 1'b0;
      end else if (Iss_valid && (int'(Iss_dest) == i)) begin
        busy_d[i] = 1'b1;
      end else if (Wr_En[i]) begin
        busy_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    qa_d        = qa_q;
    qb_d        = qb_q;
    if (accept) begin
      out_valid_d = 1'b1;
      if (rd.Ra == '0)  qa_d = '0;
      else if (fwd_a)   qa_d = Wr_D;
      else              qa_d = q_bank[rd.Ra];
      if (rd.Rb == '0)  qb_d = '0;
      else if (fwd_b)   qb_d = Wr_D;
      else              qb_d = q_bank[rd.Rb];
    end else if (rd.Out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    // NOTE: state registers use non-blocking assignments; reset clears control and data so outputs are defined.
    if (Rst) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      qa_q        <= '0;
      qb_q        <= '0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      qa_q        <= qa_d;
      qb_q        <= qb_d;
    end
  end

  assign rd.Req_ready = req_ready;
  assign rd.Out_valid = out_valid_q;
  assign rd.Qa        = qa_q;
  assign rd.Qb        = qb_q;

endmodule

// File: tb/tb_regfile_read_port.sv
// Directed bench for regfile_read_port; expectations follow RF_BYPASS_EN when it is defined.
module tb_regfile_read_port;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [1023:0] Q_flat;
  logic [31:0]   Wr_D;
  logic [31:0]   Wr_En;
  logic          Iss_valid;
  logic [4:0]    Iss_dest;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_read_port_if #(.DW(32), .IW(5)) rif ();

  regfile_read_port dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Q_flat    (Q_flat),
    .Wr_D      (Wr_D),
    .Wr_En     (Wr_En),
    .Iss_valid (Iss_valid),
    .Iss_dest  (Iss_dest),
    .rd        (rif)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_q(input int idx, input logic [31:0] v);
    Q_flat[idx*32 +: 32] = v;
  endtask

  logic [31:0] exp_drain;

  initial begin
    Rst           = 1'b1;
    Wr_D          = '0;
    Wr_En         = '0;
    Iss_valid     = 1'b0;
    Iss_dest      = '0;
    rif.Req_valid = 1'b0;
    rif.Ra        = '0;
    rif.Rb        = '0;
    rif.Out_ready = 1'b0;
    for (int i = 0; i < 32; i++) set_q(i, 32'h1000_0000 + 32'(i));
    set_q(0, 32'hFFFF_FFFF);
    set_q(3, 32'h0000_0011);
    set_q(7, 32'h0000_0022);
    #2;
    check("rst_out_valid", 32'(rif.Out_valid), 32'd0);
    check("rst_qa",        rif.Qa,             32'd0);
    check("rst_qb",        rif.Qb,             32'd0);
    check("rst_req_ready", 32'(rif.Req_ready), 32'd1);
    tick();
    Rst = 1'b0;

    // Plain read r3/r7
    rif.Req_valid = 1'b1; rif.Ra = 5'd3; rif.Rb = 5'd7; rif.Out_ready = 1'b1;
    #1 check("plain_ready", 32'(rif.Req_ready), 32'd1);
    tick();
    check("plain_valid", 32'(rif.Out_valid), 32'd1);
    check("plain_qa",    rif.Qa,             32'h11);
    check("plain_qb",    rif.Qb,             32'h22);

    // r0 reads zero, Iss_dest 0 ignored
    rif.Ra = 5'd0; rif.Rb = 5'd0; Iss_valid = 1'b1; Iss_dest = 5'd0;
    #1 check("r0_ready", 32'(rif.Req_ready), 32'd1);
    tick();
    Iss_valid = 1'b0;
    check("r0_valid", 32'(rif.Out_valid), 32'd1);
    check("r0_qa",    rif.Qa,             32'd0);
    check("r0_qb",    rif.Qb,             32'd0);
    #1 check("r0_not_busy", 32'(rif.Req_ready), 32'd1);
    rif.Req_valid = 1'b0;
    tick();
    check("drain_r0_valid", 32'(rif.Out_valid), 32'd0);

    // Hazard on r9
    Iss_valid = 1'b1; Iss_dest = 5'd9;
    tick();
    Iss_valid = 1'b0;
    rif.Req_valid = 1'b1; rif.Ra = 5'd9; rif.Rb = 5'd3;
    #1 check("hz_stall0", 32'(rif.Req_ready), 32'd0);
    tick();
    check("hz_stall1", 32'(rif.Req_ready), 32'd0);
    check("hz_no_out", 32'(rif.Out_valid), 32'd0);
    Wr_En = 32'(1) << 9; Wr_D = 32'h0000_ABCD;
    #1;
`ifdef RF_BYPASS_EN
    check("hz_fwd_ready", 32'(rif.Req_ready), 32'd1);
    tick();
    Wr_En = '0; rif.Req_valid = 1'b0;
    check("hz_valid", 32'(rif.Out_valid), 32'd1);
    check("hz_qa",    rif.Qa,             32'h0000_ABCD);
    check("hz_qb",    rif.Qb,             32'h11);
`else
    check("hz_wr_stall", 32'(rif.Req_ready), 32'd0);
    tick();
    Wr_En = '0;
    #1 check("hz_ready", 32'(rif.Req_ready), 32'd1);
    tick();
    rif.Req_valid = 1'b0;
    check("hz_valid", 32'(rif.Out_valid), 32'd1);
    check("hz_qa",    rif.Qa,             32'h1000_0009);
    check("hz_qb",    rif.Qb,             32'h11);
`endif
    tick();

    // Set/clear race on r4: issue wins
    Iss_valid = 1'b1; Iss_dest = 5'd4; Wr_En = 32'(1) << 4;
    tick();
    Iss_valid = 1'b0; Wr_En = '0;
    rif.Req_valid = 1'b1; rif.Ra = 5'd4; rif.Rb = 5'd4;
    #1 check("race_stall0", 32'(rif.Req_ready), 32'd0);
    tick();
    check("race_stall1", 32'(rif.Req_ready), 32'd0);
    Wr_En = 32'(1) << 4; Wr_D = 32'h0000_4444;
    #1;
`ifdef RF_BYPASS_EN
    check("race_fwd_ready", 32'(rif.Req_ready), 32'd1);
    tick();
    Wr_En = '0; rif.Req_valid = 1'b0;
    exp_drain = 32'h0000_4444;
`else
    check("race_wr_stall", 32'(rif.Req_ready), 32'd0);
    tick();
    Wr_En = '0;
    #1 check("race_ready", 32'(rif.Req_ready), 32'd1);
    tick();
    rif.Req_valid = 1'b0;
    exp_drain = 32'h1000_0004;
`endif
    check("race_qa", rif.Qa, exp_drain);
    check("race_qb", rif.Qb, exp_drain);
    tick();
    check("drain_valid", 32'(rif.Out_valid), 32'd0);
    check("drain_qa_kept", rif.Qa, exp_drain);

    // Backpressure: pair A held, then replaced by B in one cycle
    rif.Out_ready = 1'b0; rif.Req_valid = 1'b1; rif.Ra = 5'd3; rif.Rb = 5'd7;
    #1 check("bp_a_ready", 32'(rif.Req_ready), 32'd1);
    tick();
    rif.Ra = 5'd12; rif.Rb = 5'd13;
    set_q(3, 32'h0000_0099);
    for (int c = 0; c < 5; c++) begin
      #1 check("bp_hold_ready", 32'(rif.Req_ready), 32'd0);
      tick();
      check("bp_hold_valid", 32'(rif.Out_valid), 32'd1);
      check("bp_hold_qa",    rif.Qa,             32'h11);
      check("bp_hold_qb",    rif.Qb,             32'h22);
    end
    rif.Out_ready = 1'b1;
    #1 check("bp_b_ready", 32'(rif.Req_ready), 32'd1);
    tick();
    check("bp_b_valid", 32'(rif.Out_valid), 32'd1);
    check("bp_b_qa",    rif.Qa,             32'h1000_000C);
    check("bp_b_qb",    rif.Qb,             32'h1000_000D);

    // Reset mid-operation with r5 busy and a pair held
    rif.Req_valid = 1'b0; rif.Out_ready = 1'b0;
    Iss_valid = 1'b1; Iss_dest = 5'd5;
    tick();
    Iss_valid = 1'b0;
    check("mid_pre_valid", 32'(rif.Out_valid), 32'd1);
    rif.Req_valid = 1'b1; rif.Ra = 5'd5; rif.Rb = 5'd5;
    #1 check("mid_pre_stall", 32'(rif.Req_ready), 32'd0);
    Rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(rif.Out_valid), 32'd0);
    check("mid_rst_qa",    rif.Qa,             32'd0);
    check("mid_rst_qb",    rif.Qb,             32'd0);
    check("mid_rst_ready", 32'(rif.Req_ready), 32'd1);
    tick();
    Rst = 1'b0; rif.Out_ready = 1'b1;
    #1 check("post_rst_ready", 32'(rif.Req_ready), 32'd1);
    tick();
    check("post_rst_valid", 32'(rif.Out_valid), 32'd1);
    check("post_rst_qa",    rif.Qa,             32'h1000_0005);
    check("post_rst_qb",    rif.Qb,             32'h1000_0005);
    rif.Req_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
